priority_scan_encoder: RTL and testbench
========================================

PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the request vector width; legal range 2..1024, need not be a power of two.
REQ-002 SHALL have parameter MODE, default 0; 0 = fixed priority (lowest index first), 1 = round-robin.
REQ-003 SHALL have the port iClk, input, 1 bit, the single clock; all state is on the rising edge.
REQ-004 SHALL have the port iRst_n, input, 1 bit, the reset: asynchronous assert, active-low.
REQ-005 SHALL have the port iValid, input, 1 bit, which qualifies iData.
REQ-006 SHALL have the port oReady, output, 1 bit, which signals the block can accept a vector.
REQ-007 SHALL have the port iData, input, WIDTH bits, the multi-hot request vector.
REQ-008 SHALL have the port iClear, input, 1 bit, which flushes all pending bits.
REQ-009 SHALL have the port oValid, output, 1 bit, which qualifies oData.
REQ-010 SHALL have the port iReady, input, 1 bit, the downstream accept.
REQ-011 SHALL have the port oData, output, $clog2(WIDTH) bits, the binary index of the selected pending bit.
REQ-012 SHALL have the port oLast, output, 1 bit, set when the current index is the final pending one.
REQ-013 SHALL have the port oCount, output, $clog2(WIDTH)+1 bits, the number of pending bits.

Function
REQ-014 SHALL implement states IDLE and SCAN; oReady = 1 only in IDLE.
REQ-015 IDLE, iValid=1, iData≠0 SHALL load iData into the pending register and enter SCAN on the same edge.
REQ-016 IDLE, iValid=1, iData=0 SHALL accept and discard the vector, produce no output and stay in IDLE.
REQ-017 SHALL have oValid = 1 exactly when in SCAN, first asserted in the cycle after the load edge (latency 1).
REQ-018 SHALL hold oData, oLast and oCount stable while oValid=1 and iReady=0.
REQ-019 MODE 0 SHALL make oData the lowest set index of the pending register.
REQ-020 MODE 1 SHALL make oData the first set index at or above the pointer, wrapping from WIDTH-1 to 0.
REQ-021 On an edge with oValid=1 and iReady=1, SHALL clear the pending bit at oData and, in MODE 1, set the pointer to oData+1, wrapping WIDTH-1 to 0.
REQ-022 SHALL keep the round-robin pointer across vectors; only reset changes it otherwise.
REQ-023 SHALL have oLast = 1 iff oCount = 1; a transfer with oLast=1 SHALL return the block to IDLE, so oReady = 1 next cycle.
REQ-024 oCount SHALL be the popcount of the pending register, updated with it, and 0 in IDLE.
REQ-025 iClear=1 SHALL zero the pending register and force IDLE at the edge, overriding a simultaneous transfer or load; that transfer is not counted as delivered and the pointer is unchanged.
REQ-026 SHALL not accept a new vector in the cycle that the last transfer happens (no bypass); iValid in SCAN SHALL be ignored.
REQ-027 SHALL hold oData at 0 when oValid=0.

Reset
REQ-028 iRst_n=0 SHALL at once force IDLE, pending=0, pointer=0, oValid=0, oLast=0, oCount=0, oData=0 and oReady=1, including mid-scan.
REQ-029 Reset release SHALL be synchronised outside this block; the first load can happen on the first edge after release.

Structure
REQ-030 The mode encodings MODE_FIXED=0 and MODE_RR=1 SHALL live in the shared package enc_pkg.
REQ-031 Selection logic SHALL be one combinational sub-module priority_pick (inputs: vector, start index; outputs: index, found) that is reused in both modes; in MODE 0 the start index is tied to 0.
REQ-032 The pending register, pointer and FSM SHALL be in the top level; no other sub-modules.

Verification
REQ-033 The bench SHALL check: WIDTH=8, MODE 0, load 8'b1010_0110, iReady=1 → oData sequence 1,2,5,7; oLast only on 7; oCount 4,3,2,1; oReady high the cycle after.
REQ-034 The bench SHALL check: WIDTH=8, MODE 1, load 8'b0000_0101 and drain; then load 8'b0000_0111 → second vector gives 0,1,2 (the pointer after index 2 has wrapped to 3, then 0).
REQ-035 The bench SHALL check: WIDTH=8, MODE 1, pointer=3, load 8'b1000_1001 → oData 3,7,0.
REQ-036 The bench SHALL check: backpressure, iReady=0 for 5 cycles after the load of 8'b0001_0000 → oData=4, oValid and oCount=1 hold; transfer on the first iReady=1.
REQ-037 The bench SHALL check: iClear and iReady both 1 during a 3-bit scan → IDLE next cycle, oValid=0, oCount=0, pointer unchanged; also load of iData=0 → no oValid.
REQ-038 The bench SHALL check: WIDTH=5, iRst_n low mid-scan → all outputs at reset values without a clock edge; then load 5'b10000 → oData=4, oLast=1.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared encodings for the priority scan encoder family.
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/priority_pick.sv
// Combinational selector: first set bit of vec_i at or above start_i, wrapping to
// the lowest set bit of the whole vector when nothing is set above the start.
module priority_pick #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         vec_i,
    input  logic [$clog2(WIDTH)-1:0] start_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     found_o
);

    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] upper_mask;
    logic [WIDTH-1:0] upper_vec;
    logic [IW-1:0]    upper_idx;
    logic [IW-1:0]    any_idx;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign upper_mask[gi] = (IW'(gi) >= start_i);
        end
    endgenerate

    assign upper_vec = vec_i & upper_mask;

    // Scanning downwards lets the lowest set index win the last assignment.
    always_comb begin
        upper_idx = '0;
        any_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (upper_vec[i]) upper_idx = IW'(i);
            if (vec_i[i])     any_idx   = IW'(i);
        end
    end

    assign idx_o   = (|upper_vec) ? upper_idx : any_idx;
    assign found_o = |vec_i;

endmodule

// File: rtl/priority_scan_encoder.sv
// Accepts a multi-hot request vector and emits the index of each set bit in turn,
// either lowest-first or round-robin from a pointer that persists across vectors.
module priority_scan_encoder
    import enc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = MODE_FIXED
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [WIDTH-1:0]         iData,
    input  logic                     iClear,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [$clog2(WIDTH)-1:0] oData,
    output logic                     oLast,
    output logic [$clog2(WIDTH):0]   oCount
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [WIDTH-1:0] ONE_HOT = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    start_idx;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    next_ptr;
    logic             pick_found;
    logic [CW-1:0]    pend_cnt;
    logic             scan_active;
    logic             last_one;
    logic             xfer;

    generate
        if (MODE == MODE_RR) begin : g_rr_start
            assign start_idx = ptr_q;
        end else begin : g_fixed_start
            assign start_idx = '0;
        end
    endgenerate

    priority_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .vec_i   (pend_q),
        .start_i (start_idx),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pend_cnt = pend_cnt + CW'(pend_q[i]);
        end
    end

    assign scan_active = (state_q == ST_SCAN);
    assign last_one    = (pend_cnt == CW'(1));
    assign xfer        = scan_active && pick_found && iReady;
    assign next_ptr    = (pick_idx == IW'(WIDTH - 1)) ? '0 : pick_idx + 1'b1;

    // Clear wins over both a load in IDLE and a transfer in SCAN; pointer untouched.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        if (iClear) begin
            state_d = ST_IDLE;
            pend_d  = '0;
        end else if (state_q == ST_IDLE) begin
            if (iValid && (|iData)) begin
                pend_d  = iData;
                state_d = ST_SCAN;
            end
        end else if (xfer) begin
            pend_d = pend_q & ~(ONE_HOT << pick_idx);
            if (MODE == MODE_RR) ptr_d = next_ptr;
            if (last_one) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
        end
    end

    assign oReady = (state_q == ST_IDLE);
    assign oValid = scan_active;
    assign oData  = scan_active ? pick_idx : '0;
    assign oLast  = scan_active && last_one;
    assign oCount = pend_cnt;

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Scoreboard bench: fixed and round-robin 8-bit instances plus a 5-bit instance
// for the asynchronous reset scenario.
module tb_priority_scan_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst8_n, rst5_n;
    logic       sel_rr;
    logic       valid8, ready8, clear8;
    logic [7:0] data8;

    logic       fx_oReady, fx_oValid, fx_oLast;
    logic [2:0] fx_oData;
    logic [3:0] fx_oCount;
    logic       rr_oReady, rr_oValid, rr_oLast;
    logic [2:0] rr_oData;
    logic [3:0] rr_oCount;

    logic       o_ready8, o_valid8, o_last8;
    logic [2:0] o_data8;
    logic [3:0] o_count8;

    logic       v5, r5, clr5;
    logic [4:0] d5;
    logic       o5_ready, o5_valid, o5_last;
    logic [2:0] o5_data;
    logic [3:0] o5_count;

    typedef struct packed {
        logic [2:0] d;
        logic       l;
        logic [3:0] c;
    } exp_t;

    exp_t exp_q[$];

    priority_scan_encoder #(.WIDTH(8), .MODE(0)) u_fx (
        .iClk(clk), .iRst_n(rst8_n),
        .iValid(valid8 & ~sel_rr), .oReady(fx_oReady), .iData(data8),
        .iClear(clear8 & ~sel_rr), .oValid(fx_oValid), .iReady(ready8 & ~sel_rr),
        .oData(fx_oData), .oLast(fx_oLast), .oCount(fx_oCount)
    );

    priority_scan_encoder #(.WIDTH(8), .MODE(1)) u_rr (
        .iClk(clk), .iRst_n(rst8_n),
        .iValid(valid8 & sel_rr), .oReady(rr_oReady), .iData(data8),
        .iClear(clear8 & sel_rr), .oValid(rr_oValid), .iReady(ready8 & sel_rr),
        .oData(rr_oData), .oLast(rr_oLast), .oCount(rr_oCount)
    );

    priority_scan_encoder #(.WIDTH(5), .MODE(0)) u_w5 (
        .iClk(clk), .iRst_n(rst5_n),
        .iValid(v5), .oReady(o5_ready), .iData(d5),
        .iClear(clr5), .oValid(o5_valid), .iReady(r5),
        .oData(o5_data), .oLast(o5_last), .oCount(o5_count)
    );

    assign o_ready8 = sel_rr ? rr_oReady : fx_oReady;
    assign o_valid8 = sel_rr ? rr_oValid : fx_oValid;
    assign o_last8  = sel_rr ? rr_oLast  : fx_oLast;
    assign o_data8  = sel_rr ? rr_oData  : fx_oData;
    assign o_count8 = sel_rr ? rr_oCount : fx_oCount;

    task automatic push_exp(input logic [2:0] d, input logic l, input logic [3:0] c);
        exp_q.push_back({d, l, c});
    endtask

    task automatic load8(input logic [7:0] v);
        total++;
        if (o_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_load: got %b want 1", o_ready8);
        end
        data8  = v;
        valid8 = 1'b1;
        @(negedge clk);
        valid8 = 1'b0;
        data8  = '0;
    endtask

    task automatic drain8(input string tag);
        exp_t e;
        ready8 = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({o_valid8, o_data8, o_last8, o_count8} !== {1'b1, e}) begin
                bad++;
                $display("FAIL %s: got v=%b idx=%0d last=%b cnt=%0d want v=1 idx=%0d last=%b cnt=%0d",
                         tag, o_valid8, o_data8, o_last8, o_count8, e.d, e.l, e.c);
            end else begin
                $display("txn %s: idx=%0d last=%b cnt=%0d", tag, o_data8, o_last8, o_count8);
            end
            @(negedge clk);
        end
        ready8 = 1'b0;
        total++;
        if ({o_valid8, o_ready8, o_count8} !== {1'b0, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL %s_idle_after: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0",
                     tag, o_valid8, o_ready8, o_count8);
        end
    endtask

    task automatic test_reset();
        rst8_n = 1'b0; rst5_n = 1'b0; sel_rr = 1'b0;
        valid8 = 1'b0; ready8 = 1'b0; clear8 = 1'b0; data8 = '0;
        v5 = 1'b0; r5 = 1'b0; clr5 = 1'b0; d5 = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({fx_oReady, fx_oValid, fx_oData, fx_oLast, fx_oCount} !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL reset_fixed: got rdy=%b v=%b idx=%0d last=%b cnt=%0d want 1 0 0 0 0",
                     fx_oReady, fx_oValid, fx_oData, fx_oLast, fx_oCount);
        end
        total++;
        if ({rr_oReady, rr_oValid, rr_oData, rr_oLast, rr_oCount} !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL reset_rr: got rdy=%b v=%b idx=%0d last=%b cnt=%0d want 1 0 0 0 0",
                     rr_oReady, rr_oValid, rr_oData, rr_oLast, rr_oCount);
        end
        rst8_n = 1'b1; rst5_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed_sequence();
        sel_rr = 1'b0;
        @(negedge clk);
        load8(8'b1010_0110);
        push_exp(3'd1, 1'b0, 4'd4);
        push_exp(3'd2, 1'b0, 4'd3);
        push_exp(3'd5, 1'b0, 4'd2);
        push_exp(3'd7, 1'b1, 4'd1);
        drain8("fixed");
    endtask

    task automatic test_backpressure();
        sel_rr = 1'b0;
        @(negedge clk);
        load8(8'b0001_0000);
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({o_valid8, o_data8, o_last8, o_count8} !== {1'b1, 3'd4, 1'b1, 4'd1}) begin
                bad++;
                $display("FAIL backpressure_hold%0d: got v=%b idx=%0d last=%b cnt=%0d want 1 4 1 1",
                         k, o_valid8, o_data8, o_last8, o_count8);
            end
            @(negedge clk);
        end
        push_exp(3'd4, 1'b1, 4'd1);
        drain8("backpressure");
    endtask

    task automatic test_rr_wrap();
        sel_rr = 1'b1;
        @(negedge clk);
        load8(8'b0000_0101);
        push_exp(3'd0, 1'b0, 4'd2);
        push_exp(3'd2, 1'b1, 4'd1);
        drain8("rr_first");
        load8(8'b0000_0111);
        push_exp(3'd0, 1'b0, 4'd3);
        push_exp(3'd1, 1'b0, 4'd2);
        push_exp(3'd2, 1'b1, 4'd1);
        drain8("rr_wrap");
    endtask

    task automatic test_rr_pointer();
        sel_rr = 1'b1;
        @(negedge clk);
        load8(8'b1000_1001);
        push_exp(3'd3, 1'b0, 4'd3);
        push_exp(3'd7, 1'b0, 4'd2);
        push_exp(3'd0, 1'b1, 4'd1);
        drain8("rr_ptr3");
    endtask

    task automatic test_clear();
        sel_rr = 1'b1;
        @(negedge clk);
        load8(8'b0000_1110);
        total++;
        if ({o_valid8, o_data8, o_last8, o_count8} !== {1'b1, 3'd1, 1'b0, 4'd3}) begin
            bad++;
            $display("FAIL clear_pre: got v=%b idx=%0d last=%b cnt=%0d want 1 1 0 3",
                     o_valid8, o_data8, o_last8, o_count8);
        end
        clear8 = 1'b1;
        ready8 = 1'b1;
        @(negedge clk);
        clear8 = 1'b0;
        ready8 = 1'b0;
        total++;
        if ({o_valid8, o_ready8, o_data8, o_last8, o_count8} !== {1'b0, 1'b1, 3'd0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL clear_idle: got v=%b rdy=%b idx=%0d last=%b cnt=%0d want 0 1 0 0 0",
                     o_valid8, o_ready8, o_data8, o_last8, o_count8);
        end
        // Pointer still 1 means index 1 comes before 2.
        load8(8'b0000_0110);
        push_exp(3'd1, 1'b0, 4'd2);
        push_exp(3'd2, 1'b1, 4'd1);
        drain8("clear_ptr_kept");
    endtask

    task automatic test_zero_vector();
        sel_rr = 1'b0;
        @(negedge clk);
        load8(8'b0000_0000);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({o_valid8, o_ready8, o_count8} !== {1'b0, 1'b1, 4'd0}) begin
                bad++;
                $display("FAIL zero_vector%0d: got v=%b rdy=%b cnt=%0d want 0 1 0",
                         k, o_valid8, o_ready8, o_count8);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset_w5();
        d5 = 5'b00111;
        v5 = 1'b1;
        @(negedge clk);
        v5 = 1'b0;
        total++;
        if ({o5_valid, o5_data, o5_count} !== {1'b1, 3'd0, 4'd3}) begin
            bad++;
            $display("FAIL w5_scan: got v=%b idx=%0d cnt=%0d want 1 0 3", o5_valid, o5_data, o5_count);
        end
        rst5_n = 1'b0;
        #1;
        total++;
        if ({o5_valid, o5_ready, o5_data, o5_last, o5_count} !== {1'b0, 1'b1, 3'd0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL w5_async_reset: got v=%b rdy=%b idx=%0d last=%b cnt=%0d want 0 1 0 0 0",
                     o5_valid, o5_ready, o5_data, o5_last, o5_count);
        end else begin
            $display("txn w5_reset: outputs cleared without clock edge");
        end
        @(negedge clk);
        rst5_n = 1'b1;
        d5 = 5'b10000;
        v5 = 1'b1;
        @(negedge clk);
        v5 = 1'b0;
        total++;
        if ({o5_valid, o5_data, o5_last, o5_count} !== {1'b1, 3'd4, 1'b1, 4'd1}) begin
            bad++;
            $display("FAIL w5_load: got v=%b idx=%0d last=%b cnt=%0d want 1 4 1 1",
                     o5_valid, o5_data, o5_last, o5_count);
        end else begin
            $display("txn w5: idx=%0d last=%b cnt=%0d", o5_data, o5_last, o5_count);
        end
        r5 = 1'b1;
        @(negedge clk);
        r5 = 1'b0;
        total++;
        if ({o5_valid, o5_ready} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL w5_done: got v=%b rdy=%b want 0 1", o5_valid, o5_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_sequence();
        test_backpressure();
        test_rr_wrap();
        test_rr_pointer();
        test_clear();
        test_zero_vector();
        test_async_reset_w5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
